// File: rtl/tt_response_checker_pkg.sv
// Package for the truth-table response checker. Pulls in the shared
// definitions and wraps the state encodings in an enum type.
package tt_response_checker_pkg;

  `include "tt_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE   = TT_ST_IDLE,
    ST_SETTLE = TT_ST_SETTLE,
    ST_SAMPLE = TT_ST_SAMPLE,
    ST_DONE   = TT_ST_DONE
  } state_t;

endpackage

// File: rtl/tt_defs.vh
// Shared definitions for the truth-table response checker: FSM state
// encodings, the number of vectors in one sweep and the mismatch counter width.
`ifndef TT_DEFS_VH
`define TT_DEFS_VH

localparam logic [1:0] TT_ST_IDLE   = 2'd0;
localparam logic [1:0] TT_ST_SETTLE = 2'd1;
localparam logic [1:0] TT_ST_SAMPLE = 2'd2;
localparam logic [1:0] TT_ST_DONE   = 2'd3;

localparam int TT_VEC_CNT = 8;
localparam int TT_ERR_W   = 4;

`endif

// File: rtl/tt_settle_timer.sv
// Settle timer: down-counter that measures how long each vector is held
// before its response is sampled.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   load    : reload the counter with SETTLE-1 (start of a vector)
//   expired : counter has reached zero; this is the last settle cycle
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(SETTLE - 1);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/tt_response_checker.sv
// Truth-table response checker. Sweeps the 3-bit stimulus {a,b,c} through
// all 8 vectors, holds each one for SETTLE cycles, samples f once per vector
// and compares it against the EXPECTED truth table.
// Optional build macro: TT_STOP_ON_FAIL_EN -- end the sweep at the first
// mismatching sample instead of sweeping all 8 vectors.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : begin a sweep (honoured only when not busy)
//   f               : response of the circuit under test
//   a, b, c         : stimulus, a is the MSB of the vector index
//   busy            : sweep in progress
//   done            : sweep finished, results held
//   pass            : no mismatches (meaningful while done)
//   captured        : sampled f per vector
//   err_cnt         : mismatch count, saturates at 8
module tt_response_checker
  import tt_response_checker_pkg::*;
#(
  parameter logic [7:0] EXPECTED = 8'hE8,
  parameter int         SETTLE   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                f,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          captured,
  output logic [TT_ERR_W-1:0] err_cnt
);

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          idx;
  logic [7:0]          captured_q;
  logic [TT_ERR_W-1:0] err_q;
  logic                load;
  logic                expired;
  logic                mismatch;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .expired (expired)
  );

  assign mismatch = (f != EXPECTED[idx]);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          load      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (expired) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
`ifdef TT_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_nxt = ST_DONE;
        end else
`endif
        if (idx == 3'(TT_VEC_CNT - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
          load      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      captured_q <= 8'd0;
      err_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx        <= 3'd0;
            captured_q <= 8'd0;
            err_q      <= '0;
          end
        end
        ST_SAMPLE: begin
          captured_q[idx] <= f;
          if (mismatch && (err_q != TT_ERR_W'(TT_VEC_CNT))) begin
            err_q <= err_q + 1'b1;
          end
          // Only advance when moving on to another vector, so DONE keeps
          // presenting the last vector applied.
          if (state_nxt == ST_SETTLE) begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {a, b, c} = idx;
  assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign captured  = captured_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_tt_response_checker.sv
module tb_tt_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start2;
  logic       start1;
  logic       f;
  logic       sel1;

  logic       a2, b2, c2, busy2, done2, pass2;
  logic [7:0] cap2;
  logic [3:0] err2;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] cap1;
  logic [3:0] err1;

  logic [2:0] abc_o;
  logic       busy_o, done_o, pass_o;
  logic [7:0] cap_o;
  logic [3:0] err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tt_response_checker #(.EXPECTED(8'hE8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start2), .f(f),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .captured(cap2), .err_cnt(err2)
  );

  tt_response_checker #(.EXPECTED(8'h96), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f(f),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .err_cnt(err1)
  );

  assign abc_o  = sel1 ? {a1, b1, c1} : {a2, b2, c2};
  assign busy_o = sel1 ? busy1 : busy2;
  assign done_o = sel1 ? done1 : done2;
  assign pass_o = sel1 ? pass1 : pass2;
  assign cap_o  = sel1 ? cap1  : cap2;
  assign err_o  = sel1 ? err1  : err2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic maj(input int vi);
    return (((vi >> 2) & 1) + ((vi >> 1) & 1) + (vi & 1)) >= 2;
  endfunction

  task automatic check_idle();
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_pass", pass_o, 0);
    chk("idle_abc", abc_o, 0);
    chk("idle_cap", cap_o, 0);
    chk("idle_err", err_o, 0);
  endtask

  // mode 0: sample f = majority, f inverted on settle cycles
  // mode 1: f tied low
  // mode 2: f random on every cycle
  task automatic sweep(input int s, input int mode, input logic [7:0] exp_tab,
                       input int rst_k, input bit poke_start);
    logic [7:0] exp_cap;
    int         exp_err;
    int         vi;
    int         last_vi;
    bit         stop;
    logic       fv;
    sel1 = (s == 1);
    if (s == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    exp_cap = 8'd0; exp_err = 0; last_vi = 0; stop = 0;
    for (int k = 0; k < 8 * (s + 1); k++) begin
      if (stop) break;
      vi = k / (s + 1);
      if (k == rst_k) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle();
        repeat (8 * (s + 1) + 2) begin
          @(posedge clk); #1;
          chk("no_done_after_rst", done_o, 0);
        end
        return;
      end
      chk("sweep_busy", busy_o, 1);
      chk("sweep_done", done_o, 0);
      chk("sweep_abc", abc_o, vi);
      chk("sweep_cap", cap_o, exp_cap);
      chk("sweep_err", err_o, exp_err);
      if ((k % (s + 1)) == s) begin
        case (mode)
          0:       fv = maj(vi);
          1:       fv = 1'b0;
          default: fv = 1'($urandom);
        endcase
        f = fv;
        exp_cap[vi] = fv;
        last_vi = vi;
        if (fv != exp_tab[vi]) begin
          if (exp_err < 8) exp_err++;
`ifdef TT_STOP_ON_FAIL_EN
          stop = 1;
`endif
        end
      end else begin
        case (mode)
          0:       f = ~maj(vi);
          1:       f = 1'b0;
          default: f = 1'($urandom);
        endcase
      end
      if (poke_start && ($urandom_range(0, 2) == 0)) begin
        if (s == 1) start1 = 1'b1; else start2 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
    end
    chk("end_done", done_o, 1);
    chk("end_busy", busy_o, 0);
    chk("end_abc", abc_o, last_vi);
    chk("end_cap", cap_o, exp_cap);
    chk("end_err", err_o, exp_err);
    chk("end_pass", pass_o, exp_err == 0);
    repeat (3) begin
      f = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_done", done_o, 1);
      chk("hold_cap", cap_o, exp_cap);
      chk("hold_err", err_o, exp_err);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; f = 1'b0; sel1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sel1 = 1'b0; check_idle();
    sel1 = 1'b1; check_idle();

    // majority circuit, glitching f between samples
    sweep(2, 0, 8'hE8, -1, 0);
    // f stuck low, started straight from DONE
    sweep(2, 1, 8'hE8, -1, 0);
    // random f with start pokes while busy
    sweep(2, 2, 8'hE8, -1, 1);
    // reset while the fifth vector (idx 4) is applied
    sweep(2, 0, 8'hE8, 4 * 3 + 1, 0);
    // short settle instance
    sweep(1, 0, 8'h96, -1, 0);
    sweep(1, 2, 8'h96, -1, 1);

    // reset wins over a simultaneous start in DONE
    sel1 = 1'b1;
    rst = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0;
    check_idle();

    for (int r = 0; r < 6; r++) begin
      sweep((r % 2) + 1, 2, ((r % 2) == 0) ? 8'h96 : 8'hE8, -1, 1);
    end
    sweep(2, 2, 8'hE8, 3 * 3 + $urandom_range(0, 2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_response_checker.md
TT_RESPONSE_CHECKER -- requirements
Module: tt_response_checker

Interface
REQ-001 Parameter EXPECTED, 8 bits, default 8'hE8; bit i is the expected f for input vector i, where i = {a,b,c}.
REQ-002 Parameter SETTLE, integer, default 2; number of cycles each vector is held before f is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  begins a sweep when sampled high in IDLE or DONE.
REQ-006 f  input  1  response of the circuit under test.
REQ-007 a, b, c  output  1 each  stimulus to the circuit under test; a is the MSB of the vector index.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high while in DONE.
REQ-010 pass  output  1  valid while done is high; 1 when err_cnt == 0.
REQ-011 captured  output  8  bit i holds the sampled f for vector i.
REQ-012 err_cnt  output  4  number of mismatches; range 0..8.

Function
REQ-013 The FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL go to SETTLE with idx=0, timer=0, captured=0 and err_cnt=0.
REQ-015 In SETTLE, timer SHALL increment each cycle and SHALL go to SAMPLE on the edge where timer == SETTLE-1.
REQ-016 On the SAMPLE edge, f SHALL be written to captured[idx], and err_cnt SHALL increment if f != EXPECTED[idx].
REQ-017 After SAMPLE, if idx == 7 the FSM SHALL go to DONE; otherwise idx SHALL increment, timer SHALL reset to 0, and the FSM SHALL go to SETTLE.
REQ-018 {a,b,c} SHALL equal idx in SETTLE and SAMPLE, and SHALL hold 3'b111 (or the last vector) in DONE.
REQ-019 Values of f outside the SAMPLE cycle SHALL be ignored.
REQ-020 Each vector SHALL take SETTLE+1 cycles; a full sweep SHALL raise done exactly 8*(SETTLE+1) edges after the start-sampling edge.
REQ-021 busy SHALL be 1 in SETTLE and SAMPLE, and 0 otherwise.
REQ-022 start SHALL be ignored while busy is high.
REQ-023 DONE SHALL hold captured, err_cnt and pass until start or rst.
REQ-024 err_cnt SHALL saturate at 8 and never wrap.

Reset
REQ-025 When rst is sampled high in any state, the next state SHALL be IDLE, and rst SHALL override start.
REQ-026 Reset values: a=b=c=0, busy=0, done=0, pass=0, captured=0, err_cnt=0, idx=0, timer=0.
REQ-027 Reset mid-sweep SHALL discard the partial results, and no done pulse SHALL follow.

Configuration
REQ-028 When TT_STOP_ON_FAIL_EN is defined, the first mismatch in SAMPLE SHALL go straight to DONE with err_cnt=1 and captured bits above idx left at 0.
REQ-029 When TT_STOP_ON_FAIL_EN is undefined, all 8 vectors SHALL always be swept.

Structure
REQ-030 A shared include file tt_defs.vh SHALL hold the state encodings (2-bit localparams), the vector count (8) and the err_cnt width.
REQ-031 Sub-module tt_settle_timer SHALL implement the SETTLE down-count, with inputs clk, rst and load, and output expired.
REQ-032 The top level SHALL hold the FSM, idx, captured and err_cnt.

Verification
REQ-033 Scenario 1: with SETTLE=2 and f driven by a majority(a,b,c) model, a one-cycle start pulse -> done rises 24 cycles later, captured=8'hE8, err_cnt=0, pass=1.
REQ-034 Scenario 2: with f tied to 0 and the macro undefined -> captured=8'h00, err_cnt=4, pass=0; with the macro defined -> done after 12 cycles (at idx 3), err_cnt=1, {a,b,c}=3'b011.
REQ-035 Scenario 3: a start pulse while busy -> no effect on idx or timing; a start pulse in DONE -> err_cnt and captured cleared and a new sweep begins the next cycle.
REQ-036 Scenario 4: rst asserted while idx=4 -> next cycle in IDLE with abc=000, busy=0, captured=0, and no done afterwards.
REQ-037 Scenario 5: with the majority model, f forced to the wrong value during SETTLE cycles but correct at SAMPLE -> captured=8'hE8, pass=1.
REQ-038 Scenario 6: SETTLE=1 -> each vector takes 2 cycles and done rises after 16 cycles.
